// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with optional leading-zero blanking (blanked digits read 4'hF).
module bin2bcd_seq #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    function automatic bit digits_ok();
        logic [255:0] p;
        p = 256'd1;
        for (int i = 0; i < DIGITS; i++) p = p * 256'd10;
        return p > ((256'd1 << WIDTH) - 256'd1);
    endfunction

    function automatic logic [BCD_W-1:0] reset_bcd();
        logic [BCD_W-1:0] r;
        r = '0;
        for (int k = 1; k < DIGITS; k++) r[4*k +: 4] = BLANK_LZ ? 4'hF : 4'h0;
        return r;
    endfunction

    generate
        if (!digits_ok()) begin : g_param_check
            $error("bin2bcd_seq: DIGITS too small to represent 2**WIDTH-1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic [BCD_W-1:0]   scratch_reg, scratch_next;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   blanked;
    logic [BCD_W-1:0]   bcd_reg;
    logic               done_reg;
    logic               seen_nz;

    // Add-3 correction is per digit; no carry crosses a nibble boundary.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                    ? scratch_reg[4*gi +: 4] + 4'd3
                                    : scratch_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        {scratch_next, shift_next} = {adj, shift_reg} << 1;
    end

    // Blank from the top down until the first non-zero digit; digit0 always shows.
    always_comb begin
        blanked = scratch_reg;
        seen_nz = 1'b0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (scratch_reg[4*k +: 4] != 4'd0) seen_nz = 1'b1;
            if (BLANK_LZ && !seen_nz) blanked[4*k +: 4] = 4'hF;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg     <= '0;
            shift_reg   <= '0;
            scratch_reg <= '0;
            bcd_reg     <= reset_bcd();
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= bin;
                        scratch_reg <= '0;
                        cnt_reg     <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg   <= shift_next;
                    scratch_reg <= scratch_next;
                    cnt_reg     <= cnt_reg + 1'b1;
                end
                DONE: begin
                    bcd_reg  <= blanked;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench: a blanking and a raw-BCD instance share stimulus.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        busy, done, busy_raw, done_raw;
    logic [19:0] bcd, bcd_raw;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b0)) dut_raw (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy_raw), .done(done_raw), .bcd(bcd_raw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Issue one request and wait for done; lat = edges from accept to done (-1 on timeout).
    task automatic convert(input logic [15:0] v, output int lat, output int busy_n);
        bin = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        busy_n = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bin = 16'h0;
        repeat (3) tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bcd !== 20'hFFFF0) begin errors++; $display("FAIL reset_bcd: got %h expected FFFF0", bcd); end
        checks++; if (bcd_raw !== 20'h00000) begin errors++; $display("FAIL reset_bcd_raw: got %h expected 00000", bcd_raw); end
        $display("reset: busy=%b done=%b bcd=%h raw=%h", busy, done, bcd, bcd_raw);
    endtask

    task automatic test_zero();
        int lat, bn;
        convert(16'd0, lat, bn);
        checks++; if (lat !== 17) begin errors++; $display("FAIL zero_latency: got %0d expected 17", lat); end
        checks++; if (bn !== 17) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 17", bn); end
        checks++; if (bcd !== 20'hFFFF0) begin errors++; $display("FAIL zero_bcd: got %h expected FFFF0", bcd); end
        checks++; if (bcd_raw !== 20'h00000) begin errors++; $display("FAIL zero_bcd_raw: got %h expected 00000", bcd_raw); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
        $display("conv 0: lat=%0d busy=%0d bcd=%h raw=%h", lat, bn, bcd, bcd_raw);
    endtask

    task automatic test_values();
        logic [15:0] vin  [5] = '{16'd65535, 16'd1234, 16'd100, 16'd9, 16'd10};
        logic [19:0] vbl  [5] = '{20'h65535, 20'hF1234, 20'hFF100, 20'hFFFF9, 20'hFFF10};
        logic [19:0] vraw [5] = '{20'h65535, 20'h01234, 20'h00100, 20'h00009, 20'h00010};
        int lat, bn;
        for (int i = 0; i < 5; i++) begin
            convert(vin[i], lat, bn);
            checks++; if (lat !== 17) begin errors++; $display("FAIL val_latency[%0d]: got %0d expected 17", vin[i], lat); end
            checks++; if (bcd !== vbl[i]) begin errors++; $display("FAIL val_bcd[%0d]: got %h expected %h", vin[i], bcd, vbl[i]); end
            checks++; if (bcd_raw !== vraw[i]) begin errors++; $display("FAIL val_bcd_raw[%0d]: got %h expected %h", vin[i], bcd_raw, vraw[i]); end
            $display("conv %0d: lat=%0d bcd=%h raw=%h", vin[i], lat, bcd, bcd_raw);
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        bin = 16'd500;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        bin = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
        checks++; if (bcd !== 20'hFF500) begin errors++; $display("FAIL ignore_bcd: got %h expected FF500", bcd); end
        checks++; if (bcd_raw !== 20'h00500) begin errors++; $display("FAIL ignore_bcd_raw: got %h expected 00500", bcd_raw); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued: got busy %b expected 0", busy); end
        $display("start-while-busy: pulses=%0d bcd=%h", pulses, bcd);
    endtask

    task automatic test_back_to_back();
        int t1 = -1;
        int t2 = -1;
        bin = 16'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40 && t1 < 0; k++) begin
            tick();
            if (done) t1 = cyc;
        end
        checks++; if (bcd !== 20'hFFF42) begin errors++; $display("FAIL b2b_first_bcd: got %h expected FFF42", bcd); end
        bin = 16'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40 && t2 < 0; k++) begin
            tick();
            if (done) t2 = cyc;
        end
        checks++; if ((t1 < 0) || (t2 - t1 !== 18)) begin errors++; $display("FAIL b2b_spacing: got %0d expected 18", t2 - t1); end
        checks++; if (bcd !== 20'hFFF99) begin errors++; $display("FAIL b2b_second_bcd: got %h expected FFF99", bcd); end
        $display("back-to-back: spacing=%0d bcd=%h", t2 - t1, bcd);
        tick();
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        int lat, bn;
        bin = 16'd54321;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (bcd !== 20'hFFFF0) begin errors++; $display("FAIL abort_bcd: got %h expected FFFF0", bcd); end
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
        convert(16'd54321, lat, bn);
        checks++; if (bcd !== 20'h54321) begin errors++; $display("FAIL abort_retry_bcd: got %h expected 54321", bcd); end
        checks++; if (bcd_raw !== 20'h54321) begin errors++; $display("FAIL abort_retry_bcd_raw: got %h expected 54321", bcd_raw); end
        $display("reset-abort: pulses=%0d retry lat=%0d bcd=%h", pulses, lat, bcd);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bin = 16'h0;
        test_reset();
        test_zero();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
